aes_spi_sequencer: RTL

//  Host-side controller that runs one complete AES encryption over SPI without testbench scripting.
//  It sequences SPI_Main through three transfers to the AES_Encrypt slave: key load, message load,

---
 rtl/aes_spi_sequencer_pkg.sv | 46 ++++
 rtl/aes_spi_sequencer_timer.sv | 34 +++
 rtl/aes_spi_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_sequencer_pkg.sv
// ============================================================================
// aes_spi_pkg : shared types, widths and frame builder for the AES/SPI sequencer
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package aes_spi_pkg;

  localparam int FRAME_W = 258;
  localparam int BLK_W   = 128;
  localparam int KEY_W   = 256;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;
  localparam logic [1:0] KS_BAD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_KEY_GO   = 4'd1,
    ST_KEY_WAIT = 4'd2,
    ST_GAP      = 4'd3,
    ST_MSG_GO   = 4'd4,
    ST_MSG_WAIT = 4'd5,
    ST_RD_GO    = 4'd6,
    ST_RD_WAIT  = 4'd7,
    ST_FIN      = 4'd8,
    ST_ERR      = 4'd9
  } seq_state_t;

  // Key arrives left-aligned; the slave expects it right-aligned behind the size code.
  function automatic logic [FRAME_W-1:0] build_key_frame(input logic [1:0]       ks,
                                                         input logic [KEY_W-1:0] k);
    logic [FRAME_W-1:0] f;
    case (ks)
      KS_128:  f = {ks, 128'b0, k[KEY_W-1 -: 128]};
      KS_192:  f = {ks, 64'b0, k[KEY_W-1 -: 192]};
      default: f = {ks, k};
    endcase
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_spi_sequencer_timer.sv
// ============================================================================
// aes_seq_timer : loadable saturating down-counter with expiry flag
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_seq_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/aes_spi_sequencer.sv
// ============================================================================
// aes_spi_sequencer : drives SPI_Main through key load, message load, readback
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module aes_spi_sequencer
  import aes_spi_pkg::*;
#(
  parameter int START_LEN  = 10,
  parameter int GAP_CYCLES = 64,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         key_size,
  input  logic [0:KEY_W-1]   key,
  input  logic [0:BLK_W-1]   msg,
  input  logic               key_reuse,
  input  logic               slave_sel,
  output logic               spi_start,
  output logic               spi_sel,
  output logic [0:FRAME_W-1] spi_tx,
  input  logic [0:BLK_W-1]   spi_rx,
  input  logic               spi_done,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [0:BLK_W-1]   ciphertext
);

  localparam int MAXV = (TIMEOUT > GAP_CYCLES)
                        ? ((TIMEOUT > START_LEN) ? TIMEOUT : START_LEN)
                        : ((GAP_CYCLES > START_LEN) ? GAP_CYCLES : START_LEN);
  localparam int TW = $clog2(MAXV + 1);
  // The wait phase reloads with what is left of the timeout after the start pulse.
  localparam logic [TW-1:0] START_LD = TW'(START_LEN - 1);
  localparam logic [TW-1:0] WAIT_LD  = TW'(TIMEOUT - START_LEN);
  localparam logic [TW-1:0] GAP_LD   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_t      state;
  logic [1:0]      cur_size;
  logic [1:0]      loaded_size;
  logic [0:BLK_W-1] cur_msg;
  logic            key_valid;
  logic            after_msg;
  logic            done_seen;
  logic            spi_done_d;
  logic            done_rise;
  logic            wait_ok;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_expired;

  assign done_rise = spi_done & ~spi_done_d;
  assign wait_ok   = done_rise | done_seen;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: if (start && key_size != KS_BAD) begin
        tmr_load = 1'b1;
        tmr_val  = START_LD;
      end
      ST_KEY_GO, ST_MSG_GO, ST_RD_GO: if (tmr_expired) begin
        tmr_load = 1'b1;
        tmr_val  = WAIT_LD;
      end
      ST_KEY_WAIT, ST_MSG_WAIT: if (wait_ok) begin
        tmr_load = 1'b1;
        tmr_val  = GAP_LD;
      end
      ST_GAP: if (tmr_expired) begin
        tmr_load = 1'b1;
        tmr_val  = START_LD;
      end
      default: ;
    endcase
  end

  aes_seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      spi_start   <= 1'b0;
      spi_sel     <= 1'b0;
      spi_tx      <= '0;
      ciphertext  <= '0;
      cur_size    <= KS_128;
      loaded_size <= KS_128;
      cur_msg     <= '0;
      key_valid   <= 1'b0;
      after_msg   <= 1'b0;
      done_seen   <= 1'b0;
      spi_done_d  <= 1'b0;
    end else begin
      spi_done_d <= spi_done;
      done       <= 1'b0;
      error      <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            cur_size  <= key_size;
            cur_msg   <= msg;
            spi_sel   <= slave_sel;
            done_seen <= 1'b0;
            after_msg <= 1'b0;
            if (key_size == KS_BAD) begin
              error <= 1'b1;
              state <= ST_ERR;
            end else if (key_reuse && key_valid && key_size == loaded_size) begin
              spi_tx    <= {2'b00, 128'b0, msg};
              spi_start <= 1'b1;
              state     <= ST_MSG_GO;
            end else begin
              spi_tx    <= build_key_frame(key_size, key);
              spi_start <= 1'b1;
              key_valid <= 1'b0;
              state     <= ST_KEY_GO;
            end
          end
        end
        ST_KEY_GO, ST_MSG_GO, ST_RD_GO: begin
          done_seen <= done_seen | done_rise;
          if (tmr_expired) begin
            spi_start <= 1'b0;
            state     <= (state == ST_KEY_GO) ? ST_KEY_WAIT :
                         (state == ST_MSG_GO) ? ST_MSG_WAIT : ST_RD_WAIT;
          end
        end
        ST_KEY_WAIT, ST_MSG_WAIT, ST_RD_WAIT: begin
          // A done rise in the final timeout cycle still counts as success.
          if (wait_ok) begin
            if (state == ST_KEY_WAIT) begin
              key_valid   <= 1'b1;
              loaded_size <= cur_size;
              state       <= ST_GAP;
            end else if (state == ST_MSG_WAIT) begin
              after_msg <= 1'b1;
              state     <= ST_GAP;
            end else begin
              state <= ST_FIN;
            end
          end else if (tmr_expired) begin
            error     <= 1'b1;
            key_valid <= 1'b0;
            state     <= ST_ERR;
          end
        end
        ST_GAP: begin
          if (tmr_expired) begin
            spi_start <= 1'b1;
            done_seen <= 1'b0;
            spi_tx    <= after_msg ? '0 : {2'b00, 128'b0, cur_msg};
            state     <= after_msg ? ST_RD_GO : ST_MSG_GO;
          end
        end
        ST_FIN: begin
          ciphertext <= spi_rx;
          done       <= 1'b1;
          state      <= ST_IDLE;
        end
        ST_ERR: begin
          key_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
